i2c_sniffer: RTL and testbench

I2C_SNIFFER -- requirements
Module: i2c_sniffer

---
 rtl/i2c_sniffer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2c_sniffer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sniffer.sv
// i2c_sniffer: passive I2C bus decoder with a first-word fall-through event FIFO.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   clk_en              single-cycle sampling strobe for the bus lines
//   scl, sda            raw bus lines, asynchronous to clk
//   ev_valid/ev_ready   head-record handshake (pop on valid & ready)
//   ev_type             00 BYTE, 01 START, 10 RSTART, 11 STOP
//   ev_data, ev_ack     byte value and ACK bit (0 for non-BYTE records)
//   overflow, ovf_clr   sticky dropped-record flag and its clear
//   busy                decoder is inside a transaction
module i2c_sniffer #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       scl,
  input  logic       sda,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_type,
  output logic [7:0] ev_data,
  output logic       ev_ack,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned L_SCL = 1;
  localparam int unsigned L_SDA = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  localparam logic [1:0] EV_BYTE   = 2'b00;
  localparam logic [1:0] EV_START  = 2'b01;
  localparam logic [1:0] EV_RSTART = 2'b10;
  localparam logic [1:0] EV_STOP   = 2'b11;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] data;
    logic       ack;
  } rec_t;

  // Two-flop synchronizers, idle-high reset value
  logic [1:0] scl_sync_q, sda_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

  // Glitch filter: a line flips after FILTER_LEN consecutive differing samples
  logic [1:0]            raw_c;
  logic [1:0]            filt_q, filt_d;
  logic [1:0]            prev_q, prev_d;
  logic [1:0][CNT_W-1:0] fcnt_q, fcnt_d;

  assign raw_c = {scl_sync_q[1], sda_sync_q[1]};

  always_comb begin
    filt_d = filt_q;
    prev_d = prev_q;
    fcnt_d = fcnt_q;
    if (clk_en) begin
      prev_d = filt_q;
      for (int i = 0; i < 2; i++) begin
        if (raw_c[i] != filt_q[i]) begin
          if (fcnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
            filt_d[i] = raw_c[i];
            fcnt_d[i] = '0;
          end else begin
            fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
          end
        end else begin
          fcnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      prev_q <= prev_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Bus conditions; any sample where SCL moves is only an SCL edge
  logic scl_cur_c, scl_prev_c, sda_cur_c, sda_prev_c;
  logic scl_rise_c, scl_hi_c, start_c, stop_c;

  assign scl_cur_c  = filt_q[L_SCL];
  assign scl_prev_c = prev_q[L_SCL];
  assign sda_cur_c  = filt_q[L_SDA];
  assign sda_prev_c = prev_q[L_SDA];
  assign scl_rise_c = clk_en & scl_cur_c & ~scl_prev_c;
  assign scl_hi_c   = scl_cur_c & scl_prev_c;
  assign start_c    = clk_en & scl_hi_c & sda_prev_c & ~sda_cur_c;
  assign stop_c     = clk_en & scl_hi_c & ~sda_prev_c & sda_cur_c;

  // Decoder FSM
  state_e     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       push_c;
  rec_t       push_rec_c;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    push_rec_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          push_c         = 1'b1;
          push_rec_c.typ = EV_START;
          state_d        = ST_DATA;
          bcnt_d         = '0;
          shift_d        = '0;
        end
      end
      ST_DATA, ST_ACK: begin
        if (start_c) begin
          push_c         = 1'b1;
          push_rec_c.typ = EV_RSTART;
          state_d        = ST_DATA;
          bcnt_d         = '0;
          shift_d        = '0;
        end else if (stop_c) begin
          push_c         = 1'b1;
          push_rec_c.typ = EV_STOP;
          state_d        = ST_IDLE;
          bcnt_d         = '0;
          shift_d        = '0;
        end else if (scl_rise_c) begin
          if (state_q == ST_DATA) begin
            shift_d = {shift_q[6:0], sda_cur_c};
            if (bcnt_q == 3'd7) begin
              state_d = ST_ACK;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            push_c          = 1'b1;
            push_rec_c.typ  = EV_BYTE;
            push_rec_c.data = shift_q;
            push_rec_c.ack  = ~sda_cur_c;
            state_d         = ST_DATA;
            bcnt_d          = '0;
            shift_d         = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = '0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
    end
  end

  // Event FIFO; the head record is registered from the next read pointer
  rec_t               mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               full_q, full_d;
  logic               valid_q, valid_d;
  rec_t               head_q, head_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               pop_c, push_ok_c, drop_c;

  assign pop_c     = valid_q & ev_ready;
  assign push_ok_c = push_c & (~full_q | pop_c);
  assign drop_c    = push_c & full_q & ~pop_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push_ok_c);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop_c);
    full_d   = full_q;
    if (push_ok_c && !pop_c) begin
      full_d = (wr_ptr_d == rd_ptr_q);
    end else if (pop_c && !push_ok_c) begin
      full_d = 1'b0;
    end
    valid_d = (wr_ptr_d != rd_ptr_d) | full_d;
    // A record written into the slot about to become head bypasses the array
    if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_rec_c;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_c) begin
      mem_q[wr_ptr_q] <= push_rec_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign ev_valid = valid_q;
  assign ev_type  = head_q.typ;
  assign ev_data  = head_q.data;
  assign ev_ack   = head_q.ack;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_sniffer.sv
// tb_i2c_sniffer: drives I2C transactions (directed and random), predicts the
// record stream from the transaction description and checks it in a monitor.
module tb_i2c_sniffer;

  localparam int unsigned FLEN  = 3;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int          H     = 5;   // clk_en samples per bus phase

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] data;
    logic       ack;
  } rec_t;

  logic       clk, rst_n, clk_en, scl, sda;
  logic       ev_valid, ev_ready, ev_ack, overflow, ovf_clr, busy;
  logic [1:0] ev_type;
  logic [7:0] ev_data;

  i2c_sniffer #(.FILTER_LEN(FLEN), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .scl      (scl),
    .sda      (sda),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_type  (ev_type),
    .ev_data  (ev_data),
    .ev_ack   (ev_ack),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .busy     (busy)
  );

  int   total = 0;
  int   bad   = 0;
  rec_t exp_q [$];
  bit   stall = 0;
  bit   in_txn = 0;
  bit   stalled_mode = 0;
  int   stall_cnt = 0;
  bit   ovf_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // One sampling strobe every 4 clocks
  initial begin
    clk_en = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 clk_en = 1'b1;
      @(posedge clk);
      #1 clk_en = 1'b0;
    end
  end

  // Random back-pressure unless stalled
  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 ev_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   prev_stalled;
    int   prev_rec;
    int   cur_rec;
    rec_t r;
    prev_stalled = 0;
    prev_rec     = 0;
    forever begin
      @(negedge clk);
      if (rst_n && ev_valid) begin
        cur_rec = int'({ev_type, ev_data, ev_ack});
        if (prev_stalled) chk("head_stable", cur_rec, prev_rec);
        if (ev_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_record_qsize", exp_q.size(), 1);
          end else begin
            r = exp_q.pop_front();
            chk("ev_type", int'(ev_type), int'(r.typ));
            chk("ev_data", int'(ev_data), int'(r.data));
            chk("ev_ack", int'(ev_ack), int'(r.ack));
          end
        end
        prev_stalled = !ev_ready;
        prev_rec     = cur_rec;
      end else begin
        prev_stalled = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time=%0t limit=3000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_en();
    do @(posedge clk); while (clk_en !== 1'b1);
  endtask

  task automatic hold(input int n);
    repeat (n) wait_en();
    #1;
  endtask

  task automatic set_scl(input logic v);
    scl = v;
    hold(H);
  endtask

  task automatic set_sda(input logic v);
    sda = v;
    hold(H);
  endtask

  // Reference model: what the bus activity should produce, FIFO capacity included
  task automatic exp_push(input logic [1:0] t, input logic [7:0] d, input logic a);
    rec_t r;
    if (stalled_mode) begin
      if (stall_cnt >= int'(DEPTH)) begin
        ovf_exp = 1;
        return;
      end
      stall_cnt++;
    end
    r.typ  = t;
    r.data = d;
    r.ack  = a;
    exp_q.push_back(r);
  endtask

  task automatic send_start();
    set_sda(1'b1);
    set_scl(1'b1);
    exp_push(in_txn ? 2'b10 : 2'b01, 8'h00, 1'b0);
    set_sda(1'b0);
    set_scl(1'b0);
    in_txn = 1;
  endtask

  task automatic send_bit(input logic b);
    set_sda(b);
    set_scl(1'b1);
    set_scl(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic acked);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    if (in_txn) exp_push(2'b00, d, acked);
    send_bit(!acked);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic send_stop();
    set_sda(1'b0);
    set_scl(1'b1);
    if (in_txn) exp_push(2'b11, 8'h00, 1'b0);
    set_sda(1'b1);
    in_txn = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    scl     = 1'b1;
    sda     = 1'b1;
    ovf_clr = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ev_valid", int'(ev_valid), 0);
    chk("rst_ev_type", int'(ev_type), 0);
    chk("rst_ev_data", int'(ev_data), 0);
    chk("rst_ev_ack", int'(ev_ack), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold(H);

    // START, 0xA2 ACKed, STOP
    send_start();
    chk("busy_after_start", int'(busy), 1);
    send_byte(8'hA2, 1'b1);
    send_stop();
    chk("busy_after_stop", int'(busy), 0);
    drain("a2");

    // START, 0xFF NACKed, 3 bits, repeated START, STOP
    send_start();
    send_byte(8'hFF, 1'b0);
    send_partial(3);
    send_start();
    send_stop();
    drain("rstart");

    // Two-sample SDA glitch is filtered; three samples make START
    sda = 1'b0;
    hold(FLEN - 1);
    sda = 1'b1;
    hold(H);
    chk("glitch_busy", int'(busy), 0);
    drain("glitch");
    sda = 1'b0;
    exp_push(2'b01, 8'h00, 1'b0);
    exp_push(2'b11, 8'h00, 1'b0);
    hold(FLEN);
    sda = 1'b1;
    hold(H);
    chk("pulse3_busy", int'(busy), 0);
    drain("pulse3");

    // Overflow: consumer stalled, five records generated
    stall = 1;
    repeat (3) @(posedge clk);
    stalled_mode = 1;
    stall_cnt    = 0;
    ovf_exp      = 0;
    send_start();
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b1);
    send_stop();
    hold(H);
    chk("overflow_set", int'(overflow), int'(ovf_exp));
    chk("ovf_ev_valid", int'(ev_valid), 1);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("overflow_clr", int'(overflow), 0);
    stalled_mode = 0;
    stall        = 0;
    drain("ovf");

    // Reset in the middle of a byte
    send_start();
    send_partial(4);
    drain("pre_rst");
    #1 rst_n = 1'b0;
    in_txn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_ev_valid", int'(ev_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_partial(9);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_ev_valid", int'(ev_valid), 0);
    drain("post_rst");
    send_start();
    send_byte(8'h96, 1'b1);
    send_stop();
    drain("post_rst_txn");

    // Random transactions
    for (int t = 0; t < 8; t++) begin
      int nb;
      int ending;
      send_start();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
      ending = $urandom_range(0, 2);
      if (ending == 1) send_partial($urandom_range(0, 7));
      if (ending == 2) begin
        send_partial($urandom_range(0, 7));
        send_start();
        send_byte(8'($urandom), 1'($urandom_range(0, 1)));
      end
      send_stop();
      chk("rand_busy_idle", int'(busy), 0);
    end
    drain("random");
    chk("final_overflow", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
